fifo_occupancy_tracker: RTL
===========================

# fifo_occupancy_tracker

Parametrised successor to the team's FIFO occupancy counter for synchronous binary-pointer FIFOs. It tracks occupancy from push/pop requests and gates those requests into accepted operations for the FIFO's pointers and RAM. It provides full, empty and programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and an optional high-water mark. It sits beside the FIFO storage and pointer logic, one instance per FIFO.

## Interface
Parameters:
- FIFO_DEPTH, default 8: number of entries; integer ≥ 2, need not be a power of two.
- CW, default $clog2(FIFO_DEPTH)+1: count width, derived; not overridden by users.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  reset, asynchronous, active-low; asserting it clears all state immediately, independent of clk.
- push  input  1  write request.
- pop  input  1  read request.
- af_thresh  input  CW  almost-full threshold; legal range 1..FIFO_DEPTH; quasi-static.
- ae_thresh  input  CW  almost-empty threshold; legal range 0..FIFO_DEPTH-1; quasi-static.
- clear_stats  input  1  synchronous clear of overflow, underflow and peak.
- push_ok  output  1  accepted write (combinational).
- pop_ok  output  1  accepted read (combinational).
- count  output  CW  current occupancy, 0..FIFO_DEPTH.
- full, empty  output  1 each  count==FIFO_DEPTH / count==0.
- almost_full  output  1  count ≥ af_thresh.
- almost_empty  output  1  count ≤ ae_thresh.
- overflow, underflow  output  1 each  sticky error flags.
- peak  output  CW  high-water mark (see Configuration).

## Operation
- Acceptance:
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - Both are evaluated on the current registered count, with no priority between them.
- Count update, per accepted operation:
  - push_ok only: +1.
  - pop_ok only: −1.
  - Both, or neither: unchanged.
  - count never leaves 0..FIFO_DEPTH. There is no wrap-around.
- Simultaneous push and pop at boundaries:
  - When empty: push accepted, pop rejected, count becomes 1, underflow set.
  - When full: pop accepted, push rejected, count becomes FIFO_DEPTH−1, overflow set.
- Errors:
  - overflow sets on any cycle with push & full.
  - underflow sets on any cycle with pop & empty.
  - Both stay set until clear_stats or reset.
  - If clear_stats and a new error occur in the same cycle, the error wins and the flag is set.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count and the threshold inputs.
- Reset values:
  - count 0, empty 1, full 0, almost_empty 1.
  - almost_full 0, provided af_thresh is legal.
  - overflow 0, underflow 0, peak 0.
- Out-of-range thresholds produce undefined almost flags. The other outputs are unaffected.

## Timing
- count, overflow, underflow and peak are registered. They update on the rising clk edge after the request cycle, so latency is 1 cycle.
- push_ok and pop_ok are combinational, with zero latency from push and pop. They form the handshake to the FIFO storage: the pointers advance only on push_ok or pop_ok.
- Flags change in the same cycle as count, one cycle after the accepting request.
- A threshold change takes effect on the almost flags in the same cycle.
- Reset asserted mid-operation forces all registered state to its reset value immediately. The first update after deassertion happens on the first rising edge with reset high.

## Configuration
- Macro FIFO_OCC_PEAK_EN.
- Defined:
  - peak is a register holding the maximum count reached since reset or the last clear_stats.
  - Each cycle, peak is updated to max(peak, next count).
  - On clear_stats, peak loads the next count, not 0.
- Undefined: peak is tied to 0 and no peak register is built.

## Test plan
- Reset and fill, with FIFO_DEPTH=8, af=6, ae=2:
  - After reset release: count=0, empty=1, almost_empty=1.
  - 6 pushes: count=6 and almost_full=1 on the cycle after the 6th push; almost_empty went 0 after the 3rd push.
- Overflow:
  - Fill to 8; full=1.
  - Push again: push_ok=0, count stays 8, overflow=1.
  - Overflow persists until clear_stats; clear_stats with no push clears it.
- Underflow and empty boundary:
  - From empty, push=pop=1 in the same cycle: push_ok=1, pop_ok=0, count=1, underflow=1.
- Simultaneous steady state:
  - At count=4, push=pop=1 for 10 cycles: count stays 4, no error flags, both ok signals 1.
- Clear-versus-error collision and async reset:
  - At full, push=1 with clear_stats=1: overflow remains 1.
  - Then assert reset between clock edges: count=0 and overflow=0 immediately, without a clock edge.
- Non-power-of-two depth, FIFO_DEPTH=5, with FIFO_OCC_PEAK_EN defined:
  - Push 5, pop 3: count=2, peak=5.
  - clear_stats: peak=2.
  - With the macro undefined: peak=0 throughout.

Source files
------------

// File: rtl/fifo_occupancy_tracker.sv
// Occupancy counter, request gating and status flags for one synchronous binary-pointer FIFO.
// Define FIFO_OCC_PEAK_EN to build the high-water mark register; otherwise peak is tied to 0.
module fifo_occupancy_tracker #(
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [CW-1:0] af_thresh,
  input  logic [CW-1:0] ae_thresh,
  input  logic          clear_stats,
  output logic          push_ok,
  output logic          pop_ok,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow,
  output logic [CW-1:0] peak
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

  // Gating uses the registered count only, so a pop never frees room for a same-cycle push.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new error in the same cycle as clear_stats must leave the flag set.
  assign overflow_d  = (overflow_q & ~clear_stats) | (push & full);
  assign underflow_d = (underflow_q & ~clear_stats) | (pop & empty);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_OCC_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // Clearing restarts tracking from the occupancy being entered, not from zero.
  always_comb begin
    if (clear_stats) begin
      peak_d = count_d;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

endmodule
